fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the single-issue RV32I core. It holds the program counter and drives the word address of the asynchronous 256×32 instruction ROM. It captures the returned word into a 2-entry fetch queue and presents `{pc, instr}` to decode over a valid/ready handshake. Decode or execute can redirect the PC, which flushes the queue.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset.
- `ROM_AW`, default 8: ROM word-address width; ROM spans 4·2^ROM_AW bytes (1 KiB).
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `rom_addr`  out  ROM_AW: word address to ROM, `fetch_pc[ROM_AW+1:2]`, combinational from `fetch_pc`.
- `rom_data`  in  32: ROM read word, valid in the same cycle as `rom_addr` (asynchronous read).
- `redirect_valid`  in  1: load new PC, flush queue.
- `redirect_pc`  in  32: redirect target byte address.
- `out_valid`  out  1: queue head valid.
- `out_ready`  in  1: decode accepts head.
- `out_instr`  out  32: head instruction; 32'h0000_0013 (NOP) when queue empty.
- `out_pc`  out  32: head PC; 32'h0 when queue empty.
- `fault`  out  1: fetch fault, sticky (only with `FETCH_FAULT_EN`; tied 0 otherwise).

## Operation
- State: `fetch_pc` (32 b), queue of 2 entries `{pc, instr}`, `count` (0..2), and FSM {RUN, HALT}.
- Reset values: `fetch_pc`=RESET_PC, `count`=0, FSM=RUN, `fault`=0, `out_valid`=0, `out_instr`=NOP, `out_pc`=0.
- pop = `out_valid && out_ready`.
- push = FSM==RUN && !redirect_valid && (count<2 || pop).
- On push, `{fetch_pc, rom_data}` is written at the tail and `fetch_pc` += 4 (32-bit wrap).
- Push and pop can occur in the same cycle: count is unchanged and order is preserved. Full + pop + push is legal.
- Redirect has priority over everything. The queue is flushed (count←0) and `fetch_pc`←`redirect_pc`. A same-cycle pop counts as accepted by decode, but the entry is discarded with the rest.
- Without fault logic, `redirect_pc[1:0]` is cleared before loading. Sequential fetch past the ROM top aliases via `rom_addr` wrap, e.g. PC 0x400 reads word 0.
- HALT: no pushes; entries already queued still drain normally. HALT exits only on `rst`.

## Timing
- Fetch→output latency is 1 cycle: the word fetched in cycle n is on `out_*` with `out_valid`=1 in cycle n+1.
- First instruction after `rst` deasserts (cycle 0) appears at cycle 1.
- Redirect at cycle n: new PC is fetched at n+1 and appears at n+2. `out_valid`=0 at n+1.
- Sustained throughput is 1 instruction per cycle while `out_ready`=1.
- With `out_ready`=0, the queue fills in 2 cycles, then `fetch_pc` holds. When ready returns, output resumes the next cycle with no bubble.
- `out_*` are registered (driven from queue head), not combinational from `rom_data`.
- `rst` mid-stream drops all queued entries at the next edge.

## Configuration
- `FETCH_FAULT_EN` defined: adds misalignment and range checks.
  - A redirect with `redirect_pc[1:0]`≠0, or with `redirect_pc[31:ROM_AW+2]`≠0, sets `fault`=1 and FSM→HALT on that edge; the target is not fetched.
  - A sequential increment that would make `fetch_pc[31:ROM_AW+2]`≠0 sets `fault` and HALT instead of fetching.
- Not defined: `fault` is constant 0, FSM stays RUN, low PC bits are cleared, and addresses alias silently.

## Test plan
- **Reset and stream:** ROM[0..4] = 00200093, 00300113, 002081b3, 00400213, 003202b3; `out_ready`=1 → cycles 1..5 give `out_pc` 0,4,8,C,10 with those words, and `out_valid` stays high.
- **Backpressure:** `out_ready`=0 for cycles 1..4 → `count`=2 and `fetch_pc`=8 hold. Releasing at cycle 5 gives 0x0 then 0x4 then 0x8 on consecutive cycles, with no duplicates or losses.
- **Redirect:** `redirect_pc`=0x10 at cycle 3 with a full queue → `out_valid`=0 at cycle 4, then `out_pc`=0x10 and `out_instr`=003202b3 at cycle 5. The same-cycle pop is not replayed.
- **Simultaneous push/pop when full:** count=2 and `out_ready`=1 → count stays 2 and the PC sequence is monotonic by 4.
- **Mid-stream reset:** assert `rst` at cycle 3 for 1 cycle → `out_valid`=0 and `out_instr`=NOP the next cycle, then `out_pc`=RESET_PC one cycle after `rst` deasserts.
- **Fault (macro on):** `redirect_pc`=0x6 → `fault`=1 next cycle, no further `out_valid` after the queue drains, and `fault` is held until `rst`. Sequential fetch at 0x3FC → next fetch faults. Macro off: the same redirect fetches 0x4, and 0x400 returns ROM[0].

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, asynchronous ROM addressing and a 2-entry {pc, instr} queue.
// Optional FETCH_FAULT_EN macro adds misalignment/range checks with a sticky fault and HALT state.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_AW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              fault
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc_q    [2];
  logic [31:0] pc_d    [2];
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic [31:0] seq_pc;
  logic        pop, push, tail;

  assign rom_addr  = fetch_pc_q[ROM_AW+1:2];
  assign out_valid = (count_q != 2'd0);
  assign out_instr = out_valid ? instr_q[0] : Nop;
  assign out_pc    = out_valid ? pc_q[0] : 32'h0;

  assign pop    = out_valid && out_ready;
  assign push   = (state_q == StRun) && !redirect_valid && ((count_q != 2'd2) || pop);
  assign seq_pc = fetch_pc_q + 32'd4;
  // Entry 0 is always the head; the write slot is the occupancy after this cycle's pop.
  assign tail   = count_q[1] | (count_q[0] & ~pop);

`ifdef FETCH_FAULT_EN
  logic fault_q, fault_d;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
`ifdef FETCH_FAULT_EN
    fault_d    = fault_q;
`endif
    if (redirect_valid) begin
      // A same-cycle pop is still discarded along with the rest of the queue.
      count_d = 2'd0;
`ifdef FETCH_FAULT_EN
      if ((redirect_pc[1:0] != 2'b00) || (redirect_pc[31:ROM_AW+2] != '0)) begin
        fault_d = 1'b1;
        state_d = StHalt;
      end else begin
        fetch_pc_d = redirect_pc;
      end
`else
      fetch_pc_d = redirect_pc & ~32'h3;
`endif
    end else begin
      if (pop) begin
        pc_d[0]    = pc_q[1];
        instr_d[0] = instr_q[1];
      end
      if (push) begin
        pc_d[tail]    = fetch_pc_q;
        instr_d[tail] = rom_data;
`ifdef FETCH_FAULT_EN
        if (seq_pc[31:ROM_AW+2] != '0) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else begin
          fetch_pc_d = seq_pc;
        end
`else
        fetch_pc_d = seq_pc;
`endif
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      pc_q[0]    <= 32'h0;
      pc_q[1]    <= 32'h0;
      instr_q[0] <= Nop;
      instr_q[1] <= Nop;
`ifdef FETCH_FAULT_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
`ifdef FETCH_FAULT_EN
      fault_q    <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan sequences plus random traffic, checked every cycle
// against a queue-level reference model through a scoreboard.
module tb_fetch_stage;

  localparam int unsigned ROM_AW   = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_FAULT_EN
  localparam bit FaultEn = 1'b1;
`else
  localparam bit FaultEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] raddr;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              fault;

  logic [31:0] rom [256];
  assign rom_data = rom[rom_addr];

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .ROM_AW   (ROM_AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t expq [$];

  // Reference model: architectural PC, a plain FIFO of fetched entries, halt and fault flags.
  logic [31:0] m_pc;
  ent_t        mq [$];
  bit          m_halt;
  bit          m_fault;

  task automatic model_reset();
    m_pc    = RESET_PC;
    mq.delete();
    m_halt  = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit rv, input logic [31:0] rp, input bit rd);
    bit          popm;
    logic [31:0] nxt;
    ent_t        e;
    if (r) begin
      model_reset();
    end else begin
      popm = (mq.size() > 0) && rd;
      if (rv) begin
        mq.delete();
        if (FaultEn && ((rp % 4) != 0 || (rp >> (ROM_AW + 2)) != 0)) begin
          m_fault = 1'b1;
          m_halt  = 1'b1;
        end else begin
          m_pc = rp - (rp % 4);
        end
      end else begin
        if (popm) void'(mq.pop_front());
        if (!m_halt && mq.size() < 2) begin
          e.pc    = m_pc;
          e.instr = rom[(m_pc / 4) % 256];
          mq.push_back(e);
          nxt = m_pc + 32'd4;
          if (FaultEn && (nxt >> (ROM_AW + 2)) != 0) begin
            m_fault = 1'b1;
            m_halt  = 1'b1;
          end else begin
            m_pc = nxt;
          end
        end
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.valid = (mq.size() > 0);
    x.pc    = x.valid ? mq[0].pc : 32'h0;
    x.instr = x.valid ? mq[0].instr : 32'h0000_0013;
    x.fault = m_fault;
    x.raddr = (m_pc / 4) % 256;
    return x;
  endfunction

  // One clock cycle: record what the DUT must show now, then drive inputs for the next edge.
  task automatic step(input bit r, input bit rv, input logic [31:0] rp, input bit rd);
    @(negedge clk);
    expq.push_back(model_out());
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rd;
    model_step(r, rv, rp, rd);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
    end
  endtask

  // Monitor: compares DUT outputs with the oldest queued expectation each cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk("out_valid", {31'b0, out_valid}, {31'b0, x.valid});
        chk("out_pc", out_pc, x.pc);
        chk("out_instr", out_instr, x.instr);
        chk("fault", {31'b0, fault}, {31'b0, x.fault});
        chk("rom_addr", {{(32 - ROM_AW){1'b0}}, rom_addr}, x.raddr);
      end
    end
  end

  initial begin
    logic [31:0] rp;
    int          sel;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h0020_0093;
    rom[1] = 32'h0030_0113;
    rom[2] = 32'h0020_81b3;
    rom[3] = 32'h0040_0213;
    rom[4] = 32'h0032_02b3;
    model_reset();

    // Reset and stream
    step(1, 0, 0, 1);
    repeat (8) step(0, 0, 0, 1);

    // Backpressure then release
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);

    // Redirect with a full queue and a same-cycle pop
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 32'h10, 1);
    repeat (4) step(0, 0, 0, 1);

    // Mid-stream reset
    step(1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 1);

    // Misaligned redirect, then sequential fetch across the ROM top
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'h6, 1);
    repeat (5) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 1, 32'h3F8, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);

    // Random traffic
    step(1, 0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      sel = int'($urandom_range(0, 99));
      case ($urandom_range(0, 6))
        0:       rp = {$urandom_range(0, 255), 2'b00} + 32'd0 + {30'd0, 2'($urandom_range(1, 3))};
        1:       rp = $urandom;
        default: rp = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      step(sel < 1, (sel >= 1) && (sel < 7), rp, $urandom_range(0, 9) < 7);
    end
    repeat (3) step(0, 0, 0, 1);

    @(negedge clk);
    #5;
    chk("scoreboard_drained", expq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
